hero_write_rx: RTL
==================

Name: hero_write_rx

Overview:
- Receiver stage directly downstream of the hero write bus, which carries one hero_write_t per cycle (46 bits: cycle_type 2, wdat 36, another_type_reference 7, clk_en 1).
- The bus has no backpressure. This block frames beats into transactions, buffers them in a FIFO and presents them on a ready/valid interface.
- Each output beat carries last and err flags.
- Protocol violations and overflow are detected and reported as sticky errors.

Parameters:
- FIFO_DEPTH, 8, number of beat entries buffered (power of 2, ≥2).
- MAX_BEATS, 16, maximum beats per transaction, DONE beat included.
- BEAT_CNT_WIDTH, clog2(MAX_BEATS+1) = 5, width of the beat counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous and active-high.
- hero_write_i  in  46  hero_write_t from the bus.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_wdat  out  36  beat data.
- out_sub  out  7  sub_def_t of beat.
- out_last  out  1  final beat of transaction.
- out_err  out  1  beat is an abort terminator.
- txn_done  out  1  one-cycle pulse when a transaction closes normally.
- txn_beats  out  BEAT_CNT_WIDTH  beat count of that transaction, valid with txn_done.
- err_overflow  out  1  sticky: beat arrived while FIFO full.
- err_length  out  1  sticky: transaction exceeded MAX_BEATS.
- err_illegal  out  1  sticky: cycle_type == 3 seen.
- err_clr  in  1  clears all sticky errors.

Behaviour:
- Reset: out_valid, txn_done, all err_* = 0; txn_beats = 0; FIFO empty; FSM in IDLE.
- Input qualification:
  - Cycle is ignored entirely when clk_en = 0.
  - cycle_type IDLE(0) means no beat.
  - VALID(1) is a non-final beat; DONE(2) is the final beat. A lone DONE is a legal 1-beat transaction.
  - cycle_type 3 sets err_illegal and is otherwise treated as IDLE.
- FSM IDLE:
  - VALID: push beat (last=0), cnt=1, go to BURST.
  - DONE: push beat (last=1), pulse txn_done with txn_beats=1, stay in IDLE.
- FSM BURST:
  - VALID: push beat, cnt+1.
  - DONE: push with last=1, txn_done pulses next cycle with txn_beats=cnt+1, go to IDLE.
- Length check: if a VALID would make cnt = MAX_BEATS, the beat is dropped, err_length is set and the FSM goes to ABORT with txn_open=1. The MAX_BEATS-th beat must be DONE.
- Overflow: any beat arriving with FIFO count == FIFO_DEPTH is dropped and sets err_overflow.
  - The full test uses the registered count only; a same-cycle pop does not free space.
  - DONE dropped: go to ABORT with txn_open=0.
  - VALID dropped, or a VALID from IDLE: go to ABORT with txn_open=1.
  - A DONE dropped from IDLE pushes no terminator; it only sets err_overflow.
- FSM ABORT (terminator pending):
  - On the first cycle count < FIFO_DEPTH, push terminator {wdat=0, sub=0, last=1, err=1}. No txn_done pulse.
  - Then go to DISCARD if txn_open, else IDLE.
  - Input beats seen in ABORT are discarded. A DONE clears txn_open.
- FSM DISCARD: discard beats until DONE, then go to IDLE. Any beat arriving on the DONE cycle itself is not pushed.
- FIFO: registered, no fall-through.
  - A beat pushed in cycle N is visible on out_* in cycle N+1 at the earliest.
  - Pop occurs when out_valid & out_ready.
  - Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
  - out_* hold stable while out_valid & !out_ready.
- Sticky errors: err_clr clears them; a set condition in the same cycle as err_clr wins (error stays 1).
- Reset mid-operation discards FIFO contents and any open transaction, with no terminator emitted.

Test Plan:
- Single beat: DONE with wdat=0x123456789, out_ready=1 → next cycle out_valid=1, out_wdat=0x123456789, out_last=1, out_err=0; txn_done pulse with txn_beats=1.
- Burst: VALID×3 then DONE (wdat 1..4) with out_ready=1 → four beats in order, last only on wdat=4; txn_beats=4. Repeat with clk_en=0 interleaved → identical output.
- Overflow: out_ready=0, 10-beat burst into FIFO_DEPTH=8 → 8 beats buffered, err_overflow=1. Raise out_ready → 8 beats, then terminator (last=1, err=1, wdat=0); no txn_done.
- Length: 16 VALIDs → beats 1..15 output, then terminator; err_length=1. Subsequent beats discarded until DONE; the next transaction is received normally.
- Illegal and clear: cycle_type=3 → err_illegal=1, nothing pushed. err_clr concurrent with another cycle_type=3 → err_illegal remains 1. err_clr alone → all err_* = 0.
- Async reset asserted mid-burst with 5 beats buffered → out_valid=0 and all err_* = 0 immediately; after release, a DONE beat is received normally.

Source files
------------

// File: rtl/hero_write_rx.sv
// hero_write_rx: receiver stage behind the hero write bus.
// Frames bus beats into transactions, buffers them in a registered FIFO and
// presents them on a ready/valid interface. Protocol violations and FIFO
// overflow are reported as sticky error flags.
//
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   hero_write_i        hero_write_t from the bus (no backpressure)
//   out_valid/out_ready ready/valid handshake for the FIFO head
//   out_wdat, out_sub   beat payload
//   out_last, out_err   final-beat flag, abort-terminator flag
//   txn_done, txn_beats one-cycle pulse and beat count on a normal close
//   err_overflow        sticky: beat arrived while FIFO full
//   err_length          sticky: transaction exceeded MAX_BEATS
//   err_illegal         sticky: cycle_type 3 observed
//   err_clr             clears all sticky errors (a same-cycle set wins)
module hero_write_rx #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned MAX_BEATS      = 16,
    parameter int unsigned BEAT_CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [45:0]               hero_write_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [35:0]               out_wdat,
    output logic [6:0]                out_sub,
    output logic                      out_last,
    output logic                      out_err,
    output logic                      txn_done,
    output logic [BEAT_CNT_WIDTH-1:0] txn_beats,
    output logic                      err_overflow,
    output logic                      err_length,
    output logic                      err_illegal,
    input  logic                      err_clr
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [1:0] CT_VALID   = 2'd1;
    localparam logic [1:0] CT_DONE    = 2'd2;
    localparam logic [1:0] CT_ILLEGAL = 2'd3;

    typedef struct packed {
        logic [1:0]  cycle_type;
        logic [35:0] wdat;
        logic [6:0]  another_type_reference;
        logic        clk_en;
    } hero_write_t;

    typedef struct packed {
        logic [35:0] wdat;
        logic [6:0]  sub;
        logic        last;
        logic        err;
    } beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BURST,
        ST_ABORT,
        ST_DISCARD
    } state_t;

    hero_write_t hw;
    assign hw = hero_write_i;

    // Registered state
    state_t                    state;
    logic [BEAT_CNT_WIDTH-1:0] cnt;
    logic                      txn_open;
    beat_t                     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;

    // Next-state / decode signals
    state_t                    state_n;
    logic [BEAT_CNT_WIDTH-1:0] cnt_n;
    logic                      open_n;
    logic                      push;
    beat_t                     push_beat;
    logic                      done_pulse;
    logic [BEAT_CNT_WIDTH-1:0] beats_n;
    logic                      set_ovf;
    logic                      set_len;
    logic                      set_ill;

    logic is_valid;
    logic is_done;
    logic is_beat;
    logic full;
    logic pop;

    // Input qualification: clk_en=0 hides the whole cycle
    assign is_valid = hw.clk_en && (hw.cycle_type == CT_VALID);
    assign is_done  = hw.clk_en && (hw.cycle_type == CT_DONE);
    assign is_beat  = is_valid || is_done;

    // Full is judged on the registered count; a same-cycle pop does not help
    assign full = (count == CNT_W'(FIFO_DEPTH));
    assign pop  = out_valid && out_ready;

    // Framing decisions for the current cycle
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        open_n     = txn_open;
        push       = 1'b0;
        push_beat  = '{wdat: hw.wdat, sub: hw.another_type_reference,
                       last: is_done, err: 1'b0};
        done_pulse = 1'b0;
        beats_n    = txn_beats;
        set_ovf    = is_beat && full;
        set_len    = 1'b0;
        set_ill    = hw.clk_en && (hw.cycle_type == CT_ILLEGAL);

        case (state)
            ST_IDLE: begin
                if (is_valid) begin
                    if (full) begin
                        state_n = ST_ABORT;
                        open_n  = 1'b1;
                    end else begin
                        push    = 1'b1;
                        cnt_n   = BEAT_CNT_WIDTH'(1);
                        state_n = ST_BURST;
                    end
                end else if (is_done && !full) begin
                    // Lone DONE is a complete 1-beat transaction
                    push       = 1'b1;
                    done_pulse = 1'b1;
                    beats_n    = BEAT_CNT_WIDTH'(1);
                end
            end

            ST_BURST: begin
                if (is_valid) begin
                    if ((cnt + BEAT_CNT_WIDTH'(1)) == BEAT_CNT_WIDTH'(MAX_BEATS)) begin
                        // Only a DONE may occupy the last slot
                        set_len = 1'b1;
                        state_n = ST_ABORT;
                        open_n  = 1'b1;
                    end else if (full) begin
                        state_n = ST_ABORT;
                        open_n  = 1'b1;
                    end else begin
                        push  = 1'b1;
                        cnt_n = cnt + BEAT_CNT_WIDTH'(1);
                    end
                end else if (is_done) begin
                    if (full) begin
                        state_n = ST_ABORT;
                        open_n  = 1'b0;
                    end else begin
                        push       = 1'b1;
                        done_pulse = 1'b1;
                        beats_n    = cnt + BEAT_CNT_WIDTH'(1);
                        state_n    = ST_IDLE;
                    end
                end
            end

            ST_ABORT: begin
                // Incoming beats are dropped; a DONE closes the open transaction
                open_n = txn_open && !is_done;
                if (!full) begin
                    push      = 1'b1;
                    push_beat = '{wdat: '0, sub: '0, last: 1'b1, err: 1'b1};
                    state_n   = open_n ? ST_DISCARD : ST_IDLE;
                end
            end

            ST_DISCARD: begin
                if (is_done) begin
                    state_n = ST_IDLE;
                    open_n  = 1'b0;
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

    // Control state, counters and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            txn_open     <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            txn_done     <= 1'b0;
            txn_beats    <= '0;
            err_overflow <= 1'b0;
            err_length   <= 1'b0;
            err_illegal  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            txn_open  <= open_n;
            txn_done  <= done_pulse;
            txn_beats <= beats_n;

            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase

            // Set beats clear
            err_overflow <= set_ovf || (err_overflow && !err_clr);
            err_length   <= set_len || (err_length   && !err_clr);
            err_illegal  <= set_ill || (err_illegal  && !err_clr);
        end
    end

    // FIFO storage needs no reset: contents are qualified by count
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_beat;
    end

    // Head of FIFO, decoded from registered storage and pointers
    beat_t head;
    assign head      = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign out_wdat  = head.wdat;
    assign out_sub   = head.sub;
    assign out_last  = head.last;
    assign out_err   = head.err;

endmodule
